lbuf_queue: RTL
===============

Name: lbuf_queue

Overview:
- Parametrised load queue between the address unit and the data controller in the Tomasulo core.
- Holds up to DEPTH in-flight loads in program order and retires one at a time from the head.
- Each head load takes one of two paths: a memory read, once the ROB reports no aliasing, or store-to-load forwarding from the ROB.
- Width extension (sign/zero) is applied in-block on both paths; exact full/empty tracking; clean flush including draining an outstanding memory request.

Parameters:
- DEPTH, 8, entry count; power of two, >= 2.
- ADDR_W, 32, address width.
- XLEN, 32, data width.
- ROB_W, 4, ROB tag width; tag 0 means "no result".
- RS_SLACK, 2, free entries required to assert rs_rdy (covers dispatch pipeline lag).

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global enable; all state frozen while low
- enq_en_in  in  1  enqueue a load from the address unit
- enq_addr_in  in  ADDR_W  effective address
- enq_dest_in  in  ROB_W  destination ROB tag (non-zero)
- enq_funct3_in  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101
- lbuf_rs_rdy_out  out  1  free entries >= RS_SLACK (combinational)
- flush_in  in  1  ROB misprediction flush
- lbuf_rob_index_out  out  ROB_W  dest tag of head entry; 0 when empty (combinational)
- rob_noalias_in  in  1  no older store aliases the head
- rob_fwd_en_in  in  1  forwarding data valid for the head
- rob_fwd_data_in  in  XLEN  raw forwarded store data
- lbuf_rob_en_out  out  1  completion pulse
- lbuf_rob_h_out  out  ROB_W  completed tag
- lbuf_rob_result_out  out  XLEN  extended result
- lbuf_mem_en_out  out  1  memory read request, level-held until ack
- lbuf_mem_addr_out  out  ADDR_W  request address
- lbuf_mem_width_out  out  3  001 byte, 010 half, 100 word
- lbuf_mem_sgn_out  out  1  signed load
- mem_ack_in  in  1  read done, one-cycle pulse
- mem_data_in  in  XLEN  raw read data, low bits valid

Behaviour:
- Reset (async, rst_n_in=0):
  - head=tail=count=0, state IDLE.
  - All outputs 0: en, h, result, mem_en, addr, width, sgn.
- Storage: circular buffer of {addr, dest, funct3}; pointers wrap DEPTH-1 -> 0; count 0..DEPTH.
- Empty: count==0. Full: count==DEPTH.
- lbuf_rob_en_out and lbuf_rob_h_out are registered single-cycle pulses; they default to 0 every enabled cycle.
- Enqueue: on enq_en_in && count<DEPTH && !flush_in, write the entry at tail and increment tail.
  - Enqueue while full is dropped.
  - Simultaneous enqueue and pop leaves count unchanged.
- Head FSM states: IDLE, WAIT, DONE, DRAIN.
  - IDLE, non-empty, rob_noalias_in: register mem_en=1 with addr/width/sgn decoded from the head entry; go to WAIT. rob_noalias_in takes priority over forwarding.
  - IDLE, non-empty, !rob_noalias_in && rob_fwd_en_in: next cycle en=1, h=head dest, result=ext(rob_fwd_data_in); pop; go to DONE.
  - IDLE otherwise: stay in IDLE.
  - WAIT: mem_en stays high. On mem_ack_in: mem_en=0, en=1, h=dest, result=ext(mem_data_in); pop; go to DONE.
  - DONE: one bubble cycle so the ROB can recompute alias status for the new head; go to IDLE.
- Extension, applied on both paths:
  - LB sign-extends [7:0]; LH sign-extends [15:0].
  - LBU zero-extends [7:0]; LHU zero-extends [15:0].
  - LW passes data through.
  - Undefined funct3 gives result 0.
- Flush (synchronous, takes priority over everything except reset):
  - Clears head, tail and count; suppresses any completion in that cycle.
  - If the state is WAIT, mem_en drops to 0 and the state becomes DRAIN.
  - Otherwise the state becomes IDLE.
  - DRAIN: wait for mem_ack_in, discard the data, go to IDLE.
  - Enqueues are accepted during DRAIN; the head does not issue until IDLE.
  - An ack arriving in the same cycle as the flush is discarded and the state goes to IDLE.
- lbuf_rs_rdy_out = (DEPTH - count) >= RS_SLACK, and low during DRAIN. Must stay high at count=0 even when RS_SLACK=DEPTH.

Optional Feature:
- Macro LBUF_PERF_EN.
- Defined: adds outputs perf_mem_cnt_out[31:0] and perf_fwd_cnt_out[31:0].
  - Each saturating counter increments on a memory-path or forward-path completion respectively.
  - Both are cleared by reset only, not by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Enqueue LB addr 0x100 dest 3 with noalias=1; ack with data 0x000000F0.
  -> mem_en high with width 001, sgn 1; after ack: en=1, h=3, result 0xFFFFFFF0; state passes through DONE to IDLE.
- Head LHU dest 5 with noalias=0, fwd_en=1, fwd_data 0x1234ABCD.
  -> next cycle en=1, h=5, result 0x0000ABCD; no mem_en.
- Enqueue DEPTH=8 loads with no pops.
  -> rs_rdy drops at count 7 (RS_SLACK=2); 9th enq dropped; count stays 8; drain all 8 in order; pointer wrap verified.
- Flush in WAIT, then ack 3 cycles later.
  -> mem_en 0 immediately after the flush; no completion; state IDLE after ack; new load enqueued during DRAIN is issued afterwards.
- Simultaneous enq and ack-pop at count 4.
  -> count stays 4; rdy_in=0 for 5 cycles mid-WAIT freezes outputs; rst_n_in low mid-WAIT clears all outputs asynchronously.
- With LBUF_PERF_EN: 2 memory loads and 3 forwarded loads.
  -> perf_mem_cnt_out=2, perf_fwd_cnt_out=3; values hold across a flush.

Source files
------------

// File: rtl/lbuf_queue_if.sv
// Load-queue handshake bundle: enqueue from the address unit, ROB alias/forward/complete, memory read.
// slave = queue side, master = surrounding core (or bench).
interface lbuf_queue_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32,
    parameter int ROB_W  = 4
);
    logic              enq_en_in;
    logic [ADDR_W-1:0] enq_addr_in;
    logic [ROB_W-1:0]  enq_dest_in;
    logic [2:0]        enq_funct3_in;
    logic              lbuf_rs_rdy_out;

    logic [ROB_W-1:0]  lbuf_rob_index_out;
    logic              rob_noalias_in;
    logic              rob_fwd_en_in;
    logic [XLEN-1:0]   rob_fwd_data_in;
    logic              lbuf_rob_en_out;
    logic [ROB_W-1:0]  lbuf_rob_h_out;
    logic [XLEN-1:0]   lbuf_rob_result_out;

    logic              lbuf_mem_en_out;
    logic [ADDR_W-1:0] lbuf_mem_addr_out;
    logic [2:0]        lbuf_mem_width_out;
    logic              lbuf_mem_sgn_out;
    logic              mem_ack_in;
    logic [XLEN-1:0]   mem_data_in;

    modport slave (
        input  enq_en_in, enq_addr_in, enq_dest_in, enq_funct3_in,
        output lbuf_rs_rdy_out,
        output lbuf_rob_index_out,
        input  rob_noalias_in, rob_fwd_en_in, rob_fwd_data_in,
        output lbuf_rob_en_out, lbuf_rob_h_out, lbuf_rob_result_out,
        output lbuf_mem_en_out, lbuf_mem_addr_out, lbuf_mem_width_out, lbuf_mem_sgn_out,
        input  mem_ack_in, mem_data_in
    );

    modport master (
        output enq_en_in, enq_addr_in, enq_dest_in, enq_funct3_in,
        input  lbuf_rs_rdy_out,
        input  lbuf_rob_index_out,
        output rob_noalias_in, rob_fwd_en_in, rob_fwd_data_in,
        input  lbuf_rob_en_out, lbuf_rob_h_out, lbuf_rob_result_out,
        input  lbuf_mem_en_out, lbuf_mem_addr_out, lbuf_mem_width_out, lbuf_mem_sgn_out,
        output mem_ack_in, mem_data_in
    );
endinterface

// File: rtl/lbuf_queue.sv
// In-order load queue: head load retires via memory read (no alias) or ROB forwarding, with sign/zero extension.
// Latency: forward completes 1 cycle after issue, memory completes on the cycle after mem_ack; one bubble per retire.
// Backpressure: rs_rdy needs RS_SLACK free slots (low while draining); enq when full is dropped. LBUF_PERF_EN adds perf counters.
module lbuf_queue #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 32,
    parameter int XLEN     = 32,
    parameter int ROB_W    = 4,
    parameter int RS_SLACK = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    lbuf_queue_if.slave bus
`ifdef LBUF_PERF_EN
    ,
    output logic [31:0] perf_mem_cnt_out,
    output logic [31:0] perf_fwd_cnt_out
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

    logic [ADDR_W-1:0] addr_mem   [DEPTH];
    logic [ROB_W-1:0]  dest_mem   [DEPTH];
    logic [2:0]        funct3_mem [DEPTH];

    state_t            state_q,    state_d;
    logic [PTR_W-1:0]  head_q,     head_d;
    logic [PTR_W-1:0]  tail_q,     tail_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              rob_en_q,   rob_en_d;
    logic [ROB_W-1:0]  rob_h_q,    rob_h_d;
    logic [XLEN-1:0]   result_q,   result_d;
    logic              mem_en_q,   mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        width_q,    width_d;
    logic              sgn_q,      sgn_d;

    logic              push, pop, mem_done, fwd_done;
    logic              not_empty, not_full;
    logic [ADDR_W-1:0] head_addr;
    logic [ROB_W-1:0]  head_dest;
    logic [2:0]        head_f3;

    function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] raw, input logic [2:0] f3);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = {{(XLEN-8){raw[7]}},   raw[7:0]};
            3'b001:  r = {{(XLEN-16){raw[15]}}, raw[15:0]};
            3'b010:  r = raw;
            3'b100:  r = {{(XLEN-8){1'b0}},     raw[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}},    raw[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] width_of(input logic [2:0] f3);
        logic [2:0] w;
        case (f3[1:0])
            2'b00:   w = 3'b001;
            2'b01:   w = 3'b010;
            2'b10:   w = 3'b100;
            default: w = 3'b000;
        endcase
        return w;
    endfunction

    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != CNT_W'(DEPTH));
    assign head_addr = addr_mem[head_q];
    assign head_dest = dest_mem[head_q];
    assign head_f3   = funct3_mem[head_q];
    assign push      = bus.enq_en_in && not_full && !flush_in;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rob_en_d   = 1'b0;
        rob_h_d    = '0;
        result_d   = result_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        width_d    = width_q;
        sgn_d      = sgn_q;
        pop        = 1'b0;
        mem_done   = 1'b0;
        fwd_done   = 1'b0;

        if (flush_in) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            mem_en_d = 1'b0;
            // A request still in flight must be drained; an ack landing now closes it out.
            if ((state_q == WAIT || state_q == DRAIN) && !bus.mem_ack_in)
                state_d = DRAIN;
            else
                state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (not_empty && bus.rob_noalias_in) begin
                        mem_en_d   = 1'b1;
                        mem_addr_d = head_addr;
                        width_d    = width_of(head_f3);
                        sgn_d      = !head_f3[2];
                        state_d    = WAIT;
                    end else if (not_empty && bus.rob_fwd_en_in) begin
                        rob_en_d = 1'b1;
                        rob_h_d  = head_dest;
                        result_d = ext(bus.rob_fwd_data_in, head_f3);
                        pop      = 1'b1;
                        fwd_done = 1'b1;
                        state_d  = DONE;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack_in) begin
                        mem_en_d = 1'b0;
                        rob_en_d = 1'b1;
                        rob_h_d  = head_dest;
                        result_d = ext(bus.mem_data_in, head_f3);
                        pop      = 1'b1;
                        mem_done = 1'b1;
                        state_d  = DONE;
                    end
                end
                // Bubble lets the ROB re-evaluate aliasing against the new head.
                DONE:  state_d = IDLE;
                DRAIN: if (bus.mem_ack_in) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (pop)  head_d = head_q + PTR_W'(1);
            if (push) tail_d = tail_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rob_en_q   <= 1'b0;
            rob_h_q    <= '0;
            result_q   <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            width_q    <= '0;
            sgn_q      <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rob_en_q   <= rob_en_d;
            rob_h_q    <= rob_h_d;
            result_q   <= result_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            width_q    <= width_d;
            sgn_q      <= sgn_d;
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk_in) begin
        if (rdy_in && push) begin
            addr_mem[tail_q]   <= bus.enq_addr_in;
            dest_mem[tail_q]   <= bus.enq_dest_in;
            funct3_mem[tail_q] <= bus.enq_funct3_in;
        end
    end

`ifdef LBUF_PERF_EN
    logic [31:0] perf_mem_q, perf_mem_d;
    logic [31:0] perf_fwd_q, perf_fwd_d;

    always_comb begin
        perf_mem_d = perf_mem_q;
        perf_fwd_d = perf_fwd_q;
        if (mem_done && perf_mem_q != '1) perf_mem_d = perf_mem_q + 32'd1;
        if (fwd_done && perf_fwd_q != '1) perf_fwd_d = perf_fwd_q + 32'd1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            perf_mem_q <= '0;
            perf_fwd_q <= '0;
        end else if (rdy_in) begin
            perf_mem_q <= perf_mem_d;
            perf_fwd_q <= perf_fwd_d;
        end
    end

    assign perf_mem_cnt_out = perf_mem_q;
    assign perf_fwd_cnt_out = perf_fwd_q;
`endif

    assign bus.lbuf_rs_rdy_out = (state_q != DRAIN) &&
                                 (!not_empty || ((32'(DEPTH) - 32'(count_q)) >= 32'(RS_SLACK)));
    assign bus.lbuf_rob_index_out  = not_empty ? head_dest : '0;
    assign bus.lbuf_rob_en_out     = rob_en_q;
    assign bus.lbuf_rob_h_out      = rob_h_q;
    assign bus.lbuf_rob_result_out = result_q;
    assign bus.lbuf_mem_en_out     = mem_en_q;
    assign bus.lbuf_mem_addr_out   = mem_addr_q;
    assign bus.lbuf_mem_width_out  = width_q;
    assign bus.lbuf_mem_sgn_out    = sgn_q;
endmodule
